// File: rtl/frame_verdict_gate.sv
// Frame verdict gate: threshold-votes per-frame detector verdicts and passes, drops or tags whole frames.
// Latency: egress stream to o_out is exactly 2 cycles; o_drop is aligned with o_out.
// Backpressure: none inside; valid=0 egress beats advance nothing and flow control lives outside.
//
// Ports: i_sys_clk/i_reset_n clock and async active-low reset; i_in ingress monitor (sop/valid only);
//        i_start/i_valid/i_found per-detector verdict channel; i_fifo_out frame FIFO egress;
//        i_mode/i_threshold gating policy; o_out gated stream; o_drop condemned-beat flag;
//        o_frames_seen/o_frames_dropped saturating stats; o_overrun sticky lap/collision flag.

package frame_verdict_pkg;
    localparam int DATA_W  = 64;
    localparam int EMPTY_W = 3;

    typedef struct packed {
        logic               valid;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [DATA_W-1:0]  data;
    } avln_st;
endpackage

module frame_verdict_gate
    import frame_verdict_pkg::*;
#(
    parameter int CTR_SIZE    = 24,
    parameter int N_DET       = 4,
    parameter int FOUND_DELAY = 4,
    parameter int VDEPTH      = 64,
    parameter int STAT_W      = 32
) (
    input  logic                         i_sys_clk,
    input  logic                         i_reset_n,
    input  avln_st                       i_in,
    input  logic [N_DET-1:0]             i_start,
    input  logic [N_DET-1:0]             i_valid,
    input  logic [N_DET-1:0]             i_found,
    input  avln_st                       i_fifo_out,
    input  logic [1:0]                   i_mode,
    input  logic [$clog2(N_DET+1)-1:0]   i_threshold,
    output avln_st                       o_out,
    output logic                         o_drop,
    output logic [STAT_W-1:0]            o_frames_seen,
    output logic [STAT_W-1:0]            o_frames_dropped,
    output logic                         o_overrun
);

    localparam int SLOT_W = $clog2(VDEPTH);
    localparam int THR_W  = $clog2(N_DET+1);

    function automatic logic [THR_W-1:0] f_popcnt(input logic [N_DET-1:0] v);
        logic [THR_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_DET; i++) c = c + THR_W'(v[i]);
        return c;
    endfunction

    // frame id counters and per-detector id/verdict pipes
    logic [CTR_SIZE-1:0]    r_in_cnt;
    logic [CTR_SIZE-1:0]    r_out_cnt;
    logic [CTR_SIZE-1:0]    r_det_id  [N_DET];
    logic [FOUND_DELAY-1:0] r_pipe_vld[N_DET];
    logic [CTR_SIZE-1:0]    r_pipe_id [N_DET][FOUND_DELAY];
    logic                   r_clr_pend;
    logic                   r_overrun;

    // verdict slots: found bit and report bit per detector
    logic [N_DET-1:0]       r_found[VDEPTH];
    logic [N_DET-1:0]       r_rep  [VDEPTH];

    // egress: frame-held decision doubles as stage-1 control
    logic                   r_cond;
    logic [1:0]             r_mode;
    avln_st                 r_s1_beat;
    avln_st                 r_out;
    logic                   r_drop;
    logic [STAT_W-1:0]      r_seen;
    logic [STAT_W-1:0]      r_dropped;

    logic                   w_in_sop;
    logic                   w_eg_sop;
    logic                   w_lap;
    logic [CTR_SIZE-1:0]    w_prev_id;
    logic [SLOT_W-1:0]      w_clr_slot;
    logic [N_DET-1:0]       w_wr_vld;
    logic [SLOT_W-1:0]      w_wr_slot[N_DET];
    logic                   w_collide;
    logic [SLOT_W-1:0]      w_eg_slot;
    logic [THR_W-1:0]       w_votes;
    logic                   w_cond;
    logic [1:0]             w_mode;
    avln_st                 w_out;

    assign w_in_sop   = i_in.valid & i_in.sop;
    assign w_eg_sop   = i_fifo_out.valid & i_fifo_out.sop;
    assign w_lap      = (r_in_cnt - r_out_cnt) >= CTR_SIZE'(VDEPTH);
    // r_in_cnt already advanced past the frame whose sop arrived last cycle
    assign w_prev_id  = r_in_cnt - CTR_SIZE'(1);
    assign w_clr_slot = w_prev_id[SLOT_W-1:0];
    assign w_eg_slot  = r_out_cnt[SLOT_W-1:0];

    always_comb begin
        w_collide = 1'b0;
        for (int d = 0; d < N_DET; d++) begin
            w_wr_vld[d]  = r_pipe_vld[d][FOUND_DELAY-1];
            w_wr_slot[d] = r_pipe_id[d][FOUND_DELAY-1][SLOT_W-1:0];
            if (r_clr_pend && w_wr_vld[d] && (w_wr_slot[d] == w_clr_slot)) w_collide = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_clr_pend <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_in_sop) r_in_cnt <= r_in_cnt + CTR_SIZE'(1);
            if (w_eg_sop) r_out_cnt <= r_out_cnt + CTR_SIZE'(1);
            r_clr_pend <= w_in_sop;
            if ((w_in_sop && w_lap) || w_collide) r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int d = 0; d < N_DET; d++) begin
                r_det_id[d]   <= '0;
                r_pipe_vld[d] <= '0;
                for (int k = 0; k < FOUND_DELAY; k++) r_pipe_id[d][k] <= '0;
            end
        end else begin
            for (int d = 0; d < N_DET; d++) begin
                if (i_start[d]) r_det_id[d] <= r_in_cnt;
                r_pipe_vld[d][0] <= i_valid[d];
                r_pipe_id[d][0]  <= r_det_id[d];
                for (int k = 1; k < FOUND_DELAY; k++) begin
                    r_pipe_vld[d][k] <= r_pipe_vld[d][k-1];
                    r_pipe_id[d][k]  <= r_pipe_id[d][k-1];
                end
            end
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int s = 0; s < VDEPTH; s++) begin
                r_found[s] <= '0;
                r_rep[s]   <= '0;
            end
        end else begin
            for (int d = 0; d < N_DET; d++) begin
                if (w_wr_vld[d]) begin
                    r_found[w_wr_slot[d]][d] <= i_found[d];
                    r_rep[w_wr_slot[d]][d]   <= 1'b1;
                end
            end
            // the clear is issued last so it overrides a same-slot detector write
            if (r_clr_pend) begin
                r_found[w_clr_slot] <= '0;
                r_rep[w_clr_slot]   <= '0;
            end
        end
    end

    // decision and policy are taken at sop and held for the rest of the frame
    assign w_votes = f_popcnt(r_found[w_eg_slot]);
    assign w_cond  = w_eg_sop ? (w_votes >= i_threshold) : r_cond;
    assign w_mode  = w_eg_sop ? i_mode : r_mode;

    always_comb begin
        w_out = r_s1_beat;
        if (r_cond && (r_mode == 2'b01)) w_out.valid = 1'b0;
        if (r_cond && (r_mode == 2'b10) && r_s1_beat.eop) w_out.empty = '1;
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cond    <= 1'b0;
            r_mode    <= 2'b00;
            r_s1_beat <= '0;
            r_out     <= '0;
            r_drop    <= 1'b0;
            r_seen    <= '0;
            r_dropped <= '0;
        end else begin
            r_cond    <= w_cond;
            r_mode    <= w_mode;
            r_s1_beat <= i_fifo_out;
            r_out     <= w_out;
            r_drop    <= r_cond & r_s1_beat.valid;
            if (w_eg_sop) begin
                if (r_seen != '1) r_seen <= r_seen + STAT_W'(1);
                if (w_cond && (r_dropped != '1)) r_dropped <= r_dropped + STAT_W'(1);
            end
        end
    end

    assign o_out            = r_out;
    assign o_drop           = r_drop;
    assign o_frames_seen    = r_seen;
    assign o_frames_dropped = r_dropped;
    assign o_overrun        = r_overrun;

endmodule

// File: doc/frame_verdict_gate.md
Name: frame_verdict_gate

Overview:
Multi-detector, parametrised frame drop/tag stage placed after the detection pipeline and the frame FIFO. Up to N_DET detectors report a per-frame verdict against a frame id captured at detection start. At FIFO egress, the verdicts for each frame are combined by a threshold vote. The whole frame is then passed, dropped or tagged according to a runtime mode, and saturating statistics are kept.

Parameters:
CTR_SIZE, 24, width of ingress/egress frame counters and frame ids
N_DET, 4, number of detector channels (1..8)
FOUND_DELAY, 4, cycles from detector valid to its found being stable (>=1)
VDEPTH, 64, verdict slots (power of 2); max frames in flight between ingress and egress
STAT_W, 32, width of statistics counters

Ports:
sys_clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in  in  avln_st  ingress stream monitor (pre-FIFO); only sop/valid used
start  in  N_DET  per-detector: detection of current ingress frame begins
valid  in  N_DET  per-detector: verdict for latched frame id follows after FOUND_DELAY
found  in  N_DET  per-detector verdict, sampled FOUND_DELAY cycles after valid
fifo_out  in  avln_st  frame FIFO egress stream
mode  in  2  00 pass, 01 drop, 10 tag, 11 pass (reserved)
threshold  in  $clog2(N_DET+1)  votes needed to condemn; 0 condemns every frame
out  out  avln_st  gated egress stream
drop  out  1  high for every beat of a condemned frame (regardless of mode)
frames_seen  out  STAT_W  egress frames counted
frames_dropped  out  STAT_W  egress frames condemned
overrun  out  1  sticky: ingress lapped egress by VDEPTH frames

Behaviour:
- Reset: all counters, pipelines, verdict slots, out (all fields), drop, stats, overrun = 0.
- Frame ids: in_cnt increments on in.valid&in.sop; out_cnt increments on fifo_out.valid&fifo_out.sop. Both wrap modulo 2^CTR_SIZE; slot = id[log2(VDEPTH)-1:0].
- Per detector d: start[d] latches id_d <= in_cnt (id of the frame whose sop is on in that cycle, else next frame). valid[d] pushes id_d into a FOUND_DELAY-deep pipe. At pipe exit, found[d] is written to bit d of slot(id); the slot's report bit d is set.
- Slot clear: one cycle after an ingress sop, slot(in_cnt-1) is set to all-zero found/report. If clear and a detector write hit the same slot in one cycle, clear wins and overrun is set.
- overrun also sets when in_cnt - out_cnt >= VDEPTH at an ingress sop. Cleared only by reset.
- Vote: at egress sop, votes = popcount(found bits of slot(out_cnt)); condemn = (votes >= threshold). Missing reports count as not-found. The condemn is latched and held sop..eop inclusive; it is never re-evaluated mid-frame. Single-beat frames (sop&eop) are handled.
- Pipeline: out lags fifo_out by exactly 2 cycles; data/sop/eop/empty pass unchanged.
- out.valid: mode 01 -> valid & ~condemn; else valid.
- Mode 10: condemned frames pass with out.empty forced to all-ones on the eop beat only (tag convention).
- drop is aligned with out (same cycle as the beat it describes).
- mode/threshold are sampled at each egress sop and held for the frame.
- Stats: at egress sop, frames_seen+1. frames_dropped+1 if condemn. Both saturate at all-ones.
- Egress beats with valid=0 do not advance anything; backpressure is outside this block.

Test Plan:
- N_DET=4, threshold=2, mode=01: frame 0 found={1,1,0,0}, frame 1 found={1,0,0,0} -> frame 0 fully suppressed (out.valid=0 all beats, drop=1), frame 1 passes; frames_seen=2, frames_dropped=1.
- mode=10, same verdicts -> both frames emerge valid; frame 0 eop beat has empty=all-ones; out 2 cycles after fifo_out.
- threshold=0, no detector reports -> every frame condemned; threshold=4 with 3 votes -> passes.
- VDEPTH=4: push 5 ingress sops with no egress -> overrun=1 on 5th; survives until reset_n low.
- Back-to-back single-beat frames, alternating condemn -> drop toggles each cycle, no bleed between frames.
- Assert reset_n mid-frame -> all outputs 0 immediately; next frame after release is id 0, and verdict is from fresh reports.
